membrane_store: RTL
===================

# membrane_store

Clocked membrane-potential store and spike collector sitting on both sides of the per-neuron adder stage. It holds one WIDTH-bit membrane potential per neuron. Each timestep it streams the stored potentials into the adder's membrane input one neuron at a time. It writes back each updated potential and spike bit returned by the adder, and publishes the timestep's spike bitmap and spike count when the sweep completes.

## Interface
- WIDTH, 8, membrane potential width
- NEURONS, 16, neurons stored; index width IDX_W = $clog2(NEURONS); spike_count width CNT_W = $clog2(NEURONS+1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ts_start  in  1  request one timestep sweep; sampled only in IDLE
- mem_out_valid  out  1  membrane potential offered to adder
- mem_out_ready  in  1  adder accepts potential
- mem_out_data  out  WIDTH  stored potential of neuron cur_idx
- mem_in_valid  in  1  adder result available
- mem_in_ready  out  1  block accepts result
- mem_in_data  in  WIDTH  updated potential for neuron cur_idx
- spike_in  in  1  spike bit accompanying mem_in_data
- spike_map  out  NEURONS  bit i = neuron i spiked in last completed timestep
- spike_count  out  CNT_W  popcount of spike_map
- spike_map_valid  out  1  one-cycle pulse when spike_map/spike_count update
- busy  out  1  high in any state except IDLE

## Operation
- Storage: mem[0..NEURONS-1], WIDTH bits each; shadow bitmap shadow[NEURONS-1:0]; shadow counter acc_cnt (CNT_W); index cur_idx (IDX_W).
- FSM states: IDLE, FEED, WAIT, DONE.
- IDLE: ts_start=1 -> FEED; cur_idx<=0, shadow<=0, acc_cnt<=0.
- FEED: mem_out_valid=1, mem_out_data=mem[cur_idx]; on mem_out_valid&mem_out_ready -> WAIT.
- WAIT: mem_in_ready=1; on mem_in_valid&mem_in_ready: mem[cur_idx]<=mem_in_data, shadow[cur_idx]<=spike_in, acc_cnt<=acc_cnt+spike_in. Then if cur_idx==NEURONS-1 -> DONE, else cur_idx+1, -> FEED.
- DONE: spike_map<=shadow with final bit merged, spike_count<=acc_cnt final, spike_map_valid=1 for this cycle only; -> IDLE.
- Exactly one neuron outstanding at the adder; results are bound to cur_idx, no tags.
- mem_in_data stored verbatim. Threshold, leak and post-spike reset belong to the adder.
- spike_map/spike_count hold their values between DONE pulses; they are never partially updated mid-sweep.
- Reset values: state IDLE, every mem[i]=0, shadow=0, acc_cnt=0, cur_idx=0, spike_map=0, spike_count=0, spike_map_valid=0, mem_out_valid=0, mem_in_ready=0, busy=0.

## Timing
- mem_out_valid, mem_in_ready, spike_map_valid and busy are decoded from registered state, with no combinational path from inputs.
- ts_start sampled in IDLE at edge 0 -> FEED in cycle 1.
- Best case with ready/valid always high: each neuron takes 2 cycles (FEED, WAIT). The last writeback occurs in cycle 2·NEURONS. DONE/spike_map_valid occurs in cycle 2·NEURONS+1. IDLE occurs in cycle 2·NEURONS+2. For NEURONS=16: pulse in cycle 33.
- Stalls: mem_out_valid held high and mem_out_data held stable until accepted. mem_in_ready held high until a result arrives.
- ts_start in FEED/WAIT/DONE is ignored, not queued.
- mem_in_valid outside WAIT is not accepted; the block does not store it.
- Reset asserted mid-sweep clears all state asynchronously, including stored potentials. The sweep is abandoned and no spike_map_valid pulse is issued. The first ts_start after deassertion starts a fresh sweep from neuron 0.
- acc_cnt cannot overflow (max NEURONS fits CNT_W).

## Test plan
- Reset: assert reset mid-cycle -> all outputs 0, busy=0 without a clock edge; ts_start ignored while reset=1.
- First sweep, NEURONS=16: the responder returns mem+5 and sets spike for odd indices, with ready/valid always high. Expected: mem_out_data=0 for all 16 neurons; spike_map=16'hAAAA and spike_count=8; spike_map_valid pulses in cycle 33 only.
- Second sweep: the same responder is used. Expected: mem_out_data=5 for every neuron. Write-back then gives 10; a third sweep offers 10.
- Backpressure: mem_out_ready is low for 3 cycles on neuron 4, and mem_in_valid is delayed 4 cycles on neuron 7. Expected: mem_out_data is stable during the stall, no neuron is skipped or duplicated, and the pulse is delayed by exactly 7 cycles.
- ts_start pulsed during WAIT and during DONE -> no effect; exactly one pulse per accepted start.
- Reset at neuron 9 of a sweep -> no pulse; spike_map stays 0; the next sweep offers 0 for every neuron.

Source files
------------

// File: rtl/membrane_store.sv
// membrane_store: per-neuron membrane potential store and spike collector.
// Streams stored potentials to the adder one neuron at a time, writes back
// each returned potential and spike bit, and publishes the spike bitmap and
// count once every neuron of the timestep has been updated.
module membrane_store #(
   parameter  int WIDTH   = 8,
   parameter  int NEURONS = 16,
   localparam int IDX_W   = $clog2(NEURONS),
   localparam int CNT_W   = $clog2(NEURONS + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ts_start,
   output logic               mem_out_valid,
   input  logic               mem_out_ready,
   output logic [WIDTH-1:0]   mem_out_data,
   input  logic               mem_in_valid,
   output logic               mem_in_ready,
   input  logic [WIDTH-1:0]   mem_in_data,
   input  logic               spike_in,
   output logic [NEURONS-1:0] spike_map,
   output logic [CNT_W-1:0]   spike_count,
   output logic               spike_map_valid,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FEED = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               state_q;
   logic [IDX_W-1:0]     cur_idx_q;
   logic [NEURONS-1:0]   shadow_q;
   logic [NEURONS-1:0]   shadow_d;
   logic [CNT_W-1:0]     acc_cnt_q;
   logic [CNT_W-1:0]     acc_cnt_d;
   logic [NEURONS-1:0]   spike_map_q;
   logic [CNT_W-1:0]     spike_count_q;
   logic [WIDTH-1:0]     mem_q [NEURONS];

   logic                 feed_fire;
   logic                 wb_fire;
   logic                 last_idx;

   // Handshakes are qualified by state only, so a result offered outside
   // WAIT is never taken.
   assign feed_fire = (state_q == S_FEED) && mem_out_ready;
   assign wb_fire   = (state_q == S_WAIT) && mem_in_valid;
   assign last_idx  = (cur_idx_q == IDX_W'(NEURONS - 1));

   // Shadow bitmap and count including the result currently being written
   // back; lets the final neuron be merged straight into the published map.
   always_comb begin
      shadow_d            = shadow_q;
      shadow_d[cur_idx_q] = spike_in;
      acc_cnt_d           = acc_cnt_q + CNT_W'(spike_in);
   end

   // Sweep controller: feeds one neuron, waits for its result, repeats,
   // then publishes the completed bitmap and count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cur_idx_q     <= '0;
         shadow_q      <= '0;
         acc_cnt_q     <= '0;
         spike_map_q   <= '0;
         spike_count_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ts_start) begin
                  state_q   <= S_FEED;
                  cur_idx_q <= '0;
                  shadow_q  <= '0;
                  acc_cnt_q <= '0;
               end
            end
            S_FEED: begin
               if (feed_fire) begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wb_fire) begin
                  shadow_q  <= shadow_d;
                  acc_cnt_q <= acc_cnt_d;
                  if (last_idx) begin
                     // Published outputs change only here, so they are
                     // already valid during the DONE pulse.
                     state_q       <= S_DONE;
                     spike_map_q   <= shadow_d;
                     spike_count_q <= acc_cnt_d;
                  end else begin
                     state_q   <= S_FEED;
                     cur_idx_q <= cur_idx_q + IDX_W'(1);
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Potential storage: cleared by reset, written verbatim on writeback.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NEURONS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wb_fire) begin
         mem_q[cur_idx_q] <= mem_in_data;
      end
   end

   assign mem_out_valid   = (state_q == S_FEED);
   assign mem_in_ready    = (state_q == S_WAIT);
   assign spike_map_valid = (state_q == S_DONE);
   assign busy            = (state_q != S_IDLE);
   assign mem_out_data    = mem_q[cur_idx_q];
   assign spike_map       = spike_map_q;
   assign spike_count     = spike_count_q;

endmodule
